// File: rtl/audio_frame_sched.sv
// ---------------------------------------------------------------------------
// audio_frame_sched
//   Per-frame sample scheduler feeding the pt8211_drive serializer. On each
//   driver request it presents the frame prepared during the previous period,
//   advances both phase accumulators and then sequences the next frame. That
//   sequence shares the single sine ROM between both channels, pops the stream
//   source at most once and applies per-channel attenuation.
//
// Ports
//   clk_1p5m_w   in   1   bit clock, shared with pt8211_drive
//   rst_n        in   1   asynchronous active-low reset
//   req          in   1   one-cycle frame request from the driver
//   rom_addr     out  8   sine ROM address (registered)
//   rom_data     in   16  sine ROM word, valid one cycle after rom_addr changes
//   stream_data  in   32  {left[31:16], right[15:0]} signed stream sample
//   stream_valid in   1   stream sample available
//   stream_ready out  1   stream pop strobe
//   cfg_we       in   1   register write strobe
//   cfg_addr     in   3   0=SRC 1=INC_L 2=INC_R 3=ATT{R,L} 4=CTRL{clr_err,en}
//   cfg_wdata    in   16  register write data
//   idata_left   out  16  left sample to driver
//   idata_right  out  16  right sample to driver
//   underrun     out  1   sticky: stream sample needed but none available
//   frame_miss   out  1   sticky: request arrived during a sequence
//   busy         out  1   sequence in progress
// ---------------------------------------------------------------------------
module audio_frame_sched #(
  parameter logic [3:0]  DEF_SRC   = 4'b0110,
  parameter logic [15:0] DEF_INC_L = 16'd715,
  parameter logic [15:0] DEF_INC_R = 16'd256
) (
  input  logic        clk_1p5m_w,
  input  logic        rst_n,
  input  logic        req,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic [31:0] stream_data,
  input  logic        stream_valid,
  output logic        stream_ready,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic [15:0] idata_left,
  output logic [15:0] idata_right,
  output logic        underrun,
  output logic        frame_miss,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_L,
    S_ADDR_R,
    S_CAP_L,
    S_CAP_R,
    S_STREAM,
    S_SCALE
  } state_t;

  // Configuration registers
  logic [3:0]  r_src;
  logic [15:0] r_inc_l;
  logic [15:0] r_inc_r;
  logic [7:0]  r_att;
  logic        r_en;

  // Sequencer state
  state_t             r_state;
  logic [3:0]         r_src_f;
  logic [7:0]         r_att_f;
  logic [15:0]        r_phase_l;
  logic [15:0]        r_phase_r;
  logic signed [15:0] r_raw_l;
  logic signed [15:0] r_raw_r;
  logic signed [15:0] r_hold_l;
  logic signed [15:0] r_hold_r;
  logic signed [15:0] r_next_l;
  logic signed [15:0] r_next_r;

  // Registered outputs
  logic [15:0] r_idata_l;
  logic [15:0] r_idata_r;
  logic [7:0]  r_rom_addr;
  logic        r_stream_ready;
  logic        r_underrun;
  logic        r_frame_miss;
  logic        r_busy;

  logic w_need_stream;
  logic w_clr_err;

  assign w_need_stream = (r_src_f[1:0] == 2'd3) || (r_src_f[3:2] == 2'd3);
  assign w_clr_err     = cfg_we && (cfg_addr == 3'd4) && cfg_wdata[1];

  assign idata_left   = r_idata_l;
  assign idata_right  = r_idata_r;
  assign rom_addr     = r_rom_addr;
  assign stream_ready = r_stream_ready;
  assign underrun     = r_underrun;
  assign frame_miss   = r_frame_miss;
  assign busy         = r_busy;

  // Per-channel source mux: mute, sine ROM word, sawtooth (phase read as
  // signed), or stream sample.
  function automatic logic signed [15:0] f_pick(
    input logic [1:0]         sel,
    input logic signed [15:0] raw,
    input logic [15:0]        phase,
    input logic signed [15:0] strm
  );
    logic signed [15:0] v;
    case (sel)
      2'd0:    v = '0;
      2'd1:    v = raw;
      2'd2:    v = $signed(phase);
      default: v = strm;
    endcase
    return v;
  endfunction

  // Attenuation by 0..15 bits, arithmetic so negative samples stay negative.
  function automatic logic signed [15:0] f_atten(
    input logic signed [15:0] s,
    input logic [3:0]         sh
  );
    return s >>> sh;
  endfunction

  always_ff @(posedge clk_1p5m_w or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= DEF_SRC;
      r_inc_l <= DEF_INC_L;
      r_inc_r <= DEF_INC_R;
      r_att   <= '0;
      r_en    <= 1'b1;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    r_src   <= cfg_wdata[3:0];
        3'd1:    r_inc_l <= cfg_wdata;
        3'd2:    r_inc_r <= cfg_wdata;
        3'd3:    r_att   <= cfg_wdata[7:0];
        3'd4:    r_en    <= cfg_wdata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_1p5m_w or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_src_f        <= '0;
      r_att_f        <= '0;
      r_phase_l      <= '0;
      r_phase_r      <= '0;
      r_raw_l        <= '0;
      r_raw_r        <= '0;
      r_hold_l       <= '0;
      r_hold_r       <= '0;
      r_next_l       <= '0;
      r_next_r       <= '0;
      r_idata_l      <= '0;
      r_idata_r      <= '0;
      r_rom_addr     <= '0;
      r_stream_ready <= 1'b0;
      r_underrun     <= 1'b0;
      r_frame_miss   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      // Clear first so that a set later in this block takes priority.
      if (w_clr_err) begin
        r_underrun   <= 1'b0;
        r_frame_miss <= 1'b0;
      end

      case (r_state)
        // Frame boundary: present the prepared frame and start the next one
        S_IDLE: begin
          if (req) begin
            if (r_en) begin
              r_idata_l <= r_next_l;
              r_idata_r <= r_next_r;
              r_phase_l <= r_phase_l + r_inc_l;
              r_phase_r <= r_phase_r + r_inc_r;
              r_src_f   <= r_src;
              r_att_f   <= r_att;
              r_busy    <= 1'b1;
              r_state   <= S_ADDR_L;
            end else begin
              r_idata_l <= '0;
              r_idata_r <= '0;
              r_next_l  <= '0;
              r_next_r  <= '0;
            end
          end
        end
        // ROM address phase, left then right
        S_ADDR_L: begin
          r_rom_addr <= r_phase_l[15:8];
          r_state    <= S_ADDR_R;
        end
        S_ADDR_R: begin
          r_rom_addr <= r_phase_r[15:8];
          r_state    <= S_CAP_L;
        end
        // ROM capture phase, one cycle behind the address
        S_CAP_L: begin
          r_raw_l <= $signed(rom_data);
          r_state <= S_CAP_R;
        end
        S_CAP_R: begin
          r_raw_r        <= $signed(rom_data);
          r_stream_ready <= w_need_stream;
          r_state        <= S_STREAM;
        end
        // Stream pop; on starvation the held sample repeats
        S_STREAM: begin
          r_stream_ready <= 1'b0;
          if (r_stream_ready) begin
            if (stream_valid) begin
              r_hold_l <= $signed(stream_data[31:16]);
              r_hold_r <= $signed(stream_data[15:0]);
            end else begin
              r_underrun <= 1'b1;
            end
          end
          r_state <= S_SCALE;
        end
        // Select and attenuate into the next-frame registers
        S_SCALE: begin
          r_next_l <= f_atten(f_pick(r_src_f[1:0], r_raw_l, r_phase_l, r_hold_l), r_att_f[3:0]);
          r_next_r <= f_atten(f_pick(r_src_f[3:2], r_raw_r, r_phase_r, r_hold_r), r_att_f[7:4]);
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_stream_ready <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase

      if (req && (r_state != S_IDLE)) begin
        r_frame_miss <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_frame_sched.sv
module tb_audio_frame_sched;

  logic        clk_1p5m_w = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic [31:0] stream_data = '0;
  logic        stream_valid = 1'b0;
  logic        stream_ready;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [15:0] idata_left;
  logic [15:0] idata_right;
  logic        underrun;
  logic        frame_miss;
  logic        busy;

  audio_frame_sched dut (
    .clk_1p5m_w   (clk_1p5m_w),
    .rst_n        (rst_n),
    .req          (req),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_ready (stream_ready),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .idata_left   (idata_left),
    .idata_right  (idata_right),
    .underrun     (underrun),
    .frame_miss   (frame_miss),
    .busy         (busy)
  );

  always #5 clk_1p5m_w = ~clk_1p5m_w;

  // Sine ROM stand-in: each word encodes its own address, registered read.
  logic [15:0] rom [256];
  initial for (int i = 0; i < 256; i++) rom[i] = {8'(i), ~8'(i)};
  always @(posedge clk_1p5m_w) rom_data <= rom[rom_addr];

  int rdy_total = 0;
  always @(posedge clk_1p5m_w) if (stream_ready) rdy_total <= rdy_total + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Frame-level reference model
  logic [15:0]        m_phase_l, m_phase_r, m_inc_l, m_inc_r;
  logic signed [15:0] m_next_l, m_next_r, m_hold_l, m_hold_r;
  logic [3:0]         m_src;
  logic [7:0]         m_att;
  logic               m_en, m_unr, m_miss;

  task automatic model_reset();
    m_phase_l = 0; m_phase_r = 0; m_next_l = 0; m_next_r = 0;
    m_hold_l = 0; m_hold_r = 0; m_src = 4'b0110; m_inc_l = 16'd715;
    m_inc_r = 16'd256; m_att = 0; m_en = 1; m_unr = 0; m_miss = 0;
  endtask

  function automatic logic signed [15:0] m_chan(input logic [1:0] sel, input logic [15:0] ph,
                                                input logic signed [15:0] hold, input logic [3:0] sh);
    logic signed [15:0] s;
    case (sel)
      2'd0:    s = 0;
      2'd1:    s = rom[ph[15:8]];
      2'd2:    s = ph;
      default: s = hold;
    endcase
    return s >>> sh;
  endfunction

  task automatic model_req(input logic sv, input logic [31:0] sd,
                           output logic [15:0] el, output logic [15:0] er, output int pops);
    logic need;
    if (!m_en) begin
      el = 0; er = 0; m_next_l = 0; m_next_r = 0; pops = 0;
    end else begin
      el = m_next_l; er = m_next_r;
      m_phase_l = m_phase_l + m_inc_l;
      m_phase_r = m_phase_r + m_inc_r;
      need = (m_src[1:0] == 2'd3) || (m_src[3:2] == 2'd3);
      pops = need ? 1 : 0;
      if (need) begin
        if (sv) begin m_hold_l = sd[31:16]; m_hold_r = sd[15:0]; end
        else m_unr = 1;
      end
      m_next_l = m_chan(m_src[1:0], m_phase_l, m_hold_l, m_att[3:0]);
      m_next_r = m_chan(m_src[3:2], m_phase_r, m_hold_r, m_att[7:4]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_1p5m_w);
    req = 0; cfg_we = 0; rst_n = 0;
    @(negedge clk_1p5m_w);
    rst_n = 1;
    @(negedge clk_1p5m_w);
    model_reset();
  endtask

  task automatic cfg_wr(input logic [2:0] a, input logic [15:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk_1p5m_w);
    cfg_we = 0;
    case (a)
      3'd0: m_src = d[3:0];
      3'd1: m_inc_l = d;
      3'd2: m_inc_r = d;
      3'd3: m_att = d[7:0];
      3'd4: begin m_en = d[0]; if (d[1]) begin m_unr = 0; m_miss = 0; end end
      default: ;
    endcase
  endtask

  // One complete frame: request, then check everything the model predicts.
  task automatic run_frame(input string nm, input logic sv, input logic [31:0] sd,
                           output logic [15:0] ol, output logic [15:0] orr,
                           output logic [7:0] ral, output logic [7:0] rar);
    logic [15:0] el, er;
    int pops, r0;
    logic en_now;
    en_now = m_en;
    stream_valid = sv; stream_data = sd;
    model_req(sv, sd, el, er, pops);
    r0 = rdy_total;
    req = 1;
    @(negedge clk_1p5m_w);
    req = 0;
    ol = idata_left; orr = idata_right;
    chk({nm, ".idata_left"}, idata_left, el);
    chk({nm, ".idata_right"}, idata_right, er);
    chk({nm, ".busy_start"}, busy, en_now);
    @(negedge clk_1p5m_w);
    ral = rom_addr;
    if (en_now) chk({nm, ".rom_addr_l"}, rom_addr, m_phase_l[15:8]);
    @(negedge clk_1p5m_w);
    rar = rom_addr;
    if (en_now) chk({nm, ".rom_addr_r"}, rom_addr, m_phase_r[15:8]);
    repeat (5) @(negedge clk_1p5m_w);
    chk({nm, ".busy_end"}, busy, 0);
    chk({nm, ".underrun"}, underrun, m_unr);
    chk({nm, ".frame_miss"}, frame_miss, m_miss);
    chk({nm, ".ready_pulses"}, rdy_total - r0, pops);
  endtask

  typedef struct {
    logic [3:0]  src;
    logic [15:0] inc_l;
    logic [15:0] inc_r;
    logic [7:0]  att;
    logic        sv;
    logic [31:0] sd;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic        exp_unr;
  } vec_t;

  vec_t vt [7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ol, orr, el, er;
    logic [7:0]  ral, rar;
    logic [7:0]  exp_ral [4];
    int pops;

    vt[0] = '{4'b0110, 16'd715,  16'd256,  8'h00, 1'b0, 32'h0,         16'h02CB, 16'h01FE, 1'b0};
    vt[1] = '{4'b1111, 16'd1,    16'd1,    8'h00, 1'b1, 32'h1234ABCD,  16'h1234, 16'hABCD, 1'b0};
    vt[2] = '{4'b0010, 16'h8000, 16'h1234, 8'h04, 1'b0, 32'h0,         16'hF800, 16'h0000, 1'b0};
    vt[3] = '{4'b0010, 16'h8000, 16'h1234, 8'h00, 1'b0, 32'h0,         16'h8000, 16'h0000, 1'b0};
    vt[4] = '{4'b0101, 16'h0300, 16'h0500, 8'h21, 1'b0, 32'h0,         16'h01FE, 16'h017E, 1'b0};
    vt[5] = '{4'b1011, 16'h0000, 16'h7FF0, 8'h4F, 1'b1, 32'h8000_1111, 16'hFFFF, 16'h07FF, 1'b0};
    vt[6] = '{4'b1111, 16'd5,    16'd5,    8'h00, 1'b0, 32'h5555_AAAA, 16'h0000, 16'h0000, 1'b1};
    exp_ral[0] = 8'd2; exp_ral[1] = 8'd5; exp_ral[2] = 8'd8; exp_ral[3] = 8'd11;

    // Reset state
    do_reset();
    chk("rst.idata_left", idata_left, 0);
    chk("rst.idata_right", idata_right, 0);
    chk("rst.rom_addr", rom_addr, 0);
    chk("rst.stream_ready", stream_ready, 0);
    chk("rst.underrun", underrun, 0);
    chk("rst.frame_miss", frame_miss, 0);
    chk("rst.busy", busy, 0);

    // Default sawtooth left / sine right from reset
    for (int k = 0; k < 4; k++) begin
      run_frame("saw", 1'b0, 32'h0, ol, orr, ral, rar);
      chk($sformatf("saw%0d.idata_left", k), ol, 16'(715 * k));
      chk($sformatf("saw%0d.rom_addr_l", k), ral, exp_ral[k]);
      chk($sformatf("saw%0d.rom_addr_r", k), rar, 8'(k + 1));
    end

    // Table of configurations, each checked on the second frame after reset
    for (int i = 0; i < 7; i++) begin
      do_reset();
      cfg_wr(3'd0, {12'h0, vt[i].src});
      cfg_wr(3'd1, vt[i].inc_l);
      cfg_wr(3'd2, vt[i].inc_r);
      cfg_wr(3'd3, {8'h0, vt[i].att});
      run_frame($sformatf("vec%0d.f1", i), vt[i].sv, vt[i].sd, ol, orr, ral, rar);
      run_frame($sformatf("vec%0d.f2", i), vt[i].sv, vt[i].sd, ol, orr, ral, rar);
      chk($sformatf("vec%0d.left", i), ol, vt[i].exp_l);
      chk($sformatf("vec%0d.right", i), orr, vt[i].exp_r);
      chk($sformatf("vec%0d.underrun", i), underrun, vt[i].exp_unr);
    end

    // Stream, starvation repeat, error clear and set-beats-clear
    do_reset();
    cfg_wr(3'd0, 16'h000F);
    run_frame("str1", 1'b1, 32'h1234ABCD, ol, orr, ral, rar);
    run_frame("str2", 1'b1, 32'h1234ABCD, ol, orr, ral, rar);
    chk("str2.left", ol, 16'h1234);
    chk("str2.right", orr, 16'hABCD);
    run_frame("str3", 1'b0, 32'hDEADBEEF, ol, orr, ral, rar);
    chk("str3.underrun", underrun, 1);
    run_frame("str4", 1'b0, 32'hDEADBEEF, ol, orr, ral, rar);
    chk("str4.repeat_left", ol, 16'h1234);
    chk("str4.repeat_right", orr, 16'hABCD);
    cfg_wr(3'd4, 16'h0003);
    chk("str.clear_underrun", underrun, 0);
    stream_valid = 0;
    model_req(1'b0, 32'h0, el, er, pops);
    req = 1;
    @(negedge clk_1p5m_w);
    req = 0;
    repeat (4) @(negedge clk_1p5m_w);
    chk("setwins.stream_ready_hi", stream_ready, 1);
    cfg_we = 1; cfg_addr = 3'd4; cfg_wdata = 16'h0003;
    @(negedge clk_1p5m_w);
    cfg_we = 0;
    chk("setwins.underrun", underrun, 1);
    chk("setwins.stream_ready_lo", stream_ready, 0);
    repeat (2) @(negedge clk_1p5m_w);
    cfg_wr(3'd4, 16'h0003);
    chk("setwins.cleared", underrun, 0);

    // Request during a sequence, then disable/enable
    do_reset();
    run_frame("miss1", 1'b0, 32'h0, ol, orr, ral, rar);
    model_req(1'b0, 32'h0, el, er, pops);
    req = 1;
    @(negedge clk_1p5m_w);
    req = 0;
    chk("miss2.idata_left", idata_left, el);
    @(negedge clk_1p5m_w);
    req = 1;
    @(negedge clk_1p5m_w);
    req = 0;
    m_miss = 1;
    chk("miss.frame_miss", frame_miss, 1);
    chk("miss.idata_unchanged", idata_left, 16'd715);
    repeat (5) @(negedge clk_1p5m_w);
    chk("miss.busy_done", busy, 0);
    run_frame("miss3", 1'b0, 32'h0, ol, orr, ral, rar);
    chk("miss3.left", ol, 16'd1430);
    cfg_wr(3'd4, 16'h0000);
    run_frame("dis", 1'b0, 32'h0, ol, orr, ral, rar);
    chk("dis.left", ol, 0);
    chk("dis.right", orr, 0);
    cfg_wr(3'd4, 16'h0003);
    run_frame("ena1", 1'b0, 32'h0, ol, orr, ral, rar);
    chk("ena1.left", ol, 0);
    run_frame("ena2", 1'b0, 32'h0, ol, orr, ral, rar);
    chk("ena2.left", ol, 16'd2860);

    // Reset in the middle of a sequence
    req = 1;
    @(negedge clk_1p5m_w);
    req = 0;
    @(negedge clk_1p5m_w);
    rst_n = 0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.idata_left", idata_left, 0);
    chk("midrst.rom_addr", rom_addr, 0);
    chk("midrst.stream_ready", stream_ready, 0);
    @(negedge clk_1p5m_w);
    rst_n = 1;
    model_reset();
    @(negedge clk_1p5m_w);
    run_frame("postrst", 1'b0, 32'h0, ol, orr, ral, rar);
    chk("postrst.rom_addr_l", ral, 8'd2);

    // Randomized frames against the model
    do_reset();
    for (int f = 0; f < 80; f++) begin
      int r;
      if ($urandom_range(0, 3) == 0) cfg_wr(3'd0, 16'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) cfg_wr(3'd3, 16'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) cfg_wr(3'd1, 16'($urandom));
      if ($urandom_range(0, 4) == 0) cfg_wr(3'd2, 16'($urandom));
      r = int'($urandom_range(0, 9));
      if (r == 0) cfg_wr(3'd4, 16'h0000);
      else if (r < 3) cfg_wr(3'd4, 16'h0003);
      else if (!m_en) cfg_wr(3'd4, 16'h0001);
      run_frame($sformatf("rnd%0d", f), 1'($urandom_range(0, 1)), 32'($urandom), ol, orr, ral, rar);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
